// File: rtl/dma_copy.sv
// dma_copy: register-programmed memory-to-memory word copier with a valid/ready initiator port.
// Defining DMA_COPY_ABORT_EN adds a CTRL bit2 abort that completes the in-flight transaction first.
module dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_GAP,
    S_WR_REQ,
    S_WR_GAP
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_buf;
  logic             r_done;
  logic             r_aborted;
  logic             r_abort_req;
  logic             r_m_valid;
  logic [3:0]       r_m_wstrb;
  logic [31:0]      r_m_addr;
  logic [31:0]      r_m_wdata;

  logic        w_acc;
  logic        w_wr;
  logic        w_busy;
  logic        w_cfg_wr;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_clr;
  logic        w_abort_wr;
  logic        w_abort;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_acc     = valid & ~r_ready;
  assign w_wr      = w_acc & (wstrb != 4'h0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_cfg_wr  = w_wr & ~w_busy;
  assign w_ctrl_wr = w_wr & (addr[3:2] == 2'd3);
  assign w_start   = w_ctrl_wr & wdata[0] & ~w_busy;
  assign w_clr     = w_ctrl_wr & wdata[1];

`ifdef DMA_COPY_ABORT_EN
  assign w_abort_wr = w_ctrl_wr & wdata[2] & w_busy;
`else
  assign w_abort_wr = 1'b0;
`endif
  // An abort written this cycle is honoured at the same decision point as a pending one.
  assign w_abort = r_abort_req | w_abort_wr;

  assign w_unused = &{1'b0, addr[31:4], addr[1:0]};

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    w_rd_mux = '0;
    case (addr[3:2])
      2'd0:    w_rd_mux = r_src;
      2'd1:    w_rd_mux = r_dst;
      2'd2:    w_rd_mux = {{(32-LEN_W){1'b0}}, r_len};
      default: w_rd_mux = {28'd0, r_aborted, 1'b0, r_done, w_busy};
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments; later assignments win, so FSM
  // completion setting done overrides a done-clear written in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_buf       <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_abort_req <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_wstrb   <= '0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
    end else begin
      r_ready <= w_acc;
      if (w_acc) r_rdata <= w_rd_mux;
      if (w_cfg_wr) begin
        case (addr[3:2])
          2'd0:    r_src <= {wdata[31:2], 2'b00};
          2'd1:    r_dst <= {wdata[31:2], 2'b00};
          2'd2:    r_len <= wdata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (w_clr)      r_done      <= 1'b0;
      if (w_abort_wr) r_abort_req <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (r_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state   <= S_RD_REQ;
              r_done    <= 1'b0;
              r_aborted <= 1'b0;
            end
          end
        end
        S_RD_REQ: begin
          // The first request after start is raised one cycle after the CTRL write lands.
          if (!r_m_valid) begin
            if (w_abort) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_aborted   <= 1'b1;
              r_abort_req <= 1'b0;
            end else begin
              r_m_valid <= 1'b1;
              r_m_addr  <= r_src;
              r_m_wstrb <= 4'h0;
            end
          end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_buf     <= m_rdata;
            r_src     <= r_src + 32'd4;
            r_state   <= S_RD_GAP;
          end
        end
        S_RD_GAP: begin
          if (w_abort) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b1;
            r_aborted   <= 1'b1;
            r_abort_req <= 1'b0;
          end else begin
            r_state   <= S_WR_REQ;
            r_m_valid <= 1'b1;
            r_m_addr  <= r_dst;
            r_m_wdata <= r_buf;
            r_m_wstrb <= 4'hF;
          end
        end
        S_WR_REQ: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_wstrb <= 4'h0;
            r_dst     <= r_dst + 32'd4;
            r_len     <= r_len - LEN_W'(1);
            r_state   <= S_WR_GAP;
          end
        end
        S_WR_GAP: begin
          if (w_abort || r_len == '0) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b1;
            r_aborted   <= w_abort;
            r_abort_req <= 1'b0;
          end else begin
            r_state   <= S_RD_REQ;
            r_m_valid <= 1'b1;
            r_m_addr  <= r_src;
            r_m_wstrb <= 4'h0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready   = r_ready;
  assign rdata   = r_rdata;
  assign m_valid = r_m_valid;
  assign m_wstrb = r_m_wstrb;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

endmodule
